// File: rtl/attn_vec_packer.sv
// Byte-stream to DIM-byte vector packer with a DEPTH-entry FIFO and credit return.
// Optional trailing XOR parity byte and sticky perr output when PACKER_PARITY_EN is defined.
module attn_vec_packer #(
    parameter int DIM   = 4,
    parameter int DEPTH = 2,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic [1:0]           in_tag,
    output logic [8*DIM-1:0]     out_data,
    output logic [1:0]           out_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 crd_ret,
    output logic [CNTW-1:0]      level,
    output logic                 ovf_err,
    output logic                 frm_err
`ifdef PACKER_PARITY_EN
    ,
    output logic                 perr
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = $clog2(DIM + 2);
`ifdef PACKER_PARITY_EN
    localparam int LAST = DIM;
`else
    localparam int LAST = DIM - 1;
`endif

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t              state, state_nxt;
    logic [IW-1:0]       idx, idx_nxt, wr_pos;
    logic                byte_we, tag_we, frm_set, complete;
    logic [8*DIM-1:0]    vec_buf;
    logic [1:0]          tag_buf;

    logic [8*DIM-1:0]    mem_data [DEPTH];
    logic [1:0]          mem_tag  [DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [CNTW-1:0]     count;
    logic [8*DIM-1:0]    cand_vec;
    logic                par_ok, push_req, full, pop, push, ovf_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // A sof byte always restarts assembly; it is only a framing error if it cut a vector short.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        wr_pos    = idx;
        byte_we   = 1'b0;
        tag_we    = 1'b0;
        frm_set   = 1'b0;
        complete  = 1'b0;
        if (in_valid) begin
            if (in_sof) begin
                byte_we   = 1'b1;
                tag_we    = 1'b1;
                wr_pos    = '0;
                idx_nxt   = IW'(1);
                state_nxt = COLLECT;
                frm_set   = (state == COLLECT);
            end else if (state == IDLE) begin
                frm_set = 1'b1;
            end else if (idx == IW'(LAST)) begin
                complete  = 1'b1;
                idx_nxt   = '0;
                state_nxt = IDLE;
            end else begin
                byte_we = 1'b1;
                idx_nxt = idx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_buf <= '0;
            tag_buf <= '0;
        end else begin
            for (int i = 0; i < DIM; i++) begin
                if (byte_we && wr_pos == IW'(i))
                    vec_buf[i*8 +: 8] <= in_data;
            end
            if (tag_we)
                tag_buf <= in_tag;
        end
    end

`ifdef PACKER_PARITY_EN
    logic [7:0] par_calc;
    logic       par_fail;

    always_comb begin
        par_calc = 8'h00;
        for (int i = 0; i < DIM; i++)
            par_calc = par_calc ^ vec_buf[i*8 +: 8];
    end

    assign cand_vec = vec_buf;
    assign par_ok   = (par_calc == in_data);
    assign par_fail = complete & ~par_ok;
`else
    // The final byte goes straight into the FIFO entry, so it never lands in vec_buf.
    assign cand_vec = {in_data, vec_buf[8*(DIM-1)-1:0]};
    assign par_ok   = 1'b1;
`endif

    assign push_req  = complete & par_ok;
    assign full      = (count == CNTW'(DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign push      = push_req & (~full | pop);
    assign ovf_set   = push_req & full & ~pop;
    assign out_data  = mem_data[rd_ptr];
    assign out_tag   = mem_tag[rd_ptr];
    assign level     = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_tag[i]  <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= cand_vec;
                mem_tag[wr_ptr]  <= tag_buf;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CNTW'(1);
            else if (pop && !push)
                count <= count - CNTW'(1);
            if (ovf_set)
                ovf_err <= 1'b1;
            if (frm_set)
                frm_err <= 1'b1;
        end
    end

`ifdef PACKER_PARITY_EN
    // A pop and a parity refund can land together; the spare credit is paid out a cycle later.
    logic [1:0] crd_pend;
    logic [2:0] crd_sum;

    assign crd_sum = {1'b0, crd_pend} + {2'b00, pop} + {2'b00, par_fail};

    always_ff @(posedge clk) begin
        if (rst) begin
            crd_ret  <= 1'b0;
            crd_pend <= '0;
            perr     <= 1'b0;
        end else begin
            crd_ret <= (crd_sum != 3'd0);
            if (crd_sum != 3'd0)
                crd_pend <= 2'(crd_sum - 3'd1);
            if (par_fail)
                perr <= 1'b1;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst)
            crd_ret <= 1'b0;
        else
            crd_ret <= pop;
    end
`endif

endmodule
